// File: rtl/ddfs_qw_pkg.sv
// Shared constants and helpers for the quarter-wave DDFS.
// The ROM table is computed here at elaboration so no external init file is needed.
package ddfs_pkg;

   localparam int DEF_ACC_W  = 24;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_OUT_W  = 8;

   // Bit positions inside the two-bit quadrant field at the top of the phase
   localparam int QUAD_MIRROR_BIT = 0;
   localparam int QUAD_SIGN_BIT   = 1;

   localparam longint PI_Q30 = 64'd3373259426;

   typedef enum logic {
      LOAD_IDLE = 1'b0,
      LOAD_PEND = 1'b1
   } load_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // rom[k] = round((2**(out_w-1)-1) * sin((k+0.5)*pi/2**(addr_w-1))),
   // evaluated with a Q30 Taylor series; the half-LSB offset keeps mirroring exact.
   function automatic int rom_sample(input int k, input int addr_w, input int out_w);
      longint x;
      longint x2;
      longint term;
      longint sum;
      longint amp;
      x    = (longint'(2 * k + 1) * PI_Q30) >>> addr_w;
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 9; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      amp = (longint'(1) <<< (out_w - 1)) - 1;
      return int'((sum * amp + (longint'(1) <<< 29)) >>> 30);
   endfunction

endpackage

// File: rtl/ddfs_qw_if.sv
// Control and sample bus between the register block, the DDFS and the DAC datapath.
interface ddfs_qw_if
   import ddfs_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int OUT_W  = DEF_OUT_W
);
   logic                     en;
   logic [ACC_W-1:0]         fcw;
   logic                     fcw_valid;
   logic                     fcw_ready;
   logic [ADDR_W-1:0]        phase_off;
   logic                     sync_clr;
   logic signed [OUT_W-1:0]  dout;
   logic                     dout_valid;
   logic                     wrap;

   modport master (
      output en, fcw, fcw_valid, phase_off, sync_clr,
      input  fcw_ready, dout, dout_valid, wrap
   );

   modport slave (
      input  en, fcw, fcw_valid, phase_off, sync_clr,
      output fcw_ready, dout, dout_valid, wrap
   );
endinterface

// File: rtl/ddfs_qw_rom.sv
// Quarter-wave sine magnitude ROM with a registered one-cycle read.
module ddfs_qw_rom
   import ddfs_pkg::*;
#(
   parameter int AW = DEF_ADDR_W - 2,
   parameter int DW = DEF_OUT_W - 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] mag
);

   logic [DW-1:0] rom_tbl [2**AW];

   for (genvar k = 0; k < 2**AW; k++) begin : g_entry
      localparam int sample_val = rom_sample(k, AW + 2, DW + 1);
      assign rom_tbl[k] = DW'(sample_val);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mag <= '0;
      else        mag <= rom_tbl[addr];
   end

endmodule

// File: rtl/ddfs_qw.sv
// Parametrised DDFS: phase accumulator, valid/ready frequency-word load and
// a three-stage quarter-wave sine pipeline producing signed samples.
module ddfs_qw
   import ddfs_pkg::*;
#(
   parameter int ACC_W    = DEF_ACC_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int OUT_W    = DEF_OUT_W,
   parameter bit COHERENT = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   ddfs_qw_if.slave bus
);

   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        fcw_act;
   logic [ACC_W:0]          acc_sum;
   logic                    carry;
   logic                    wrap_q;
   logic                    fcw_ready_q;
   logic [ADDR_W-1:0]       phase;
   logic [ADDR_W-3:0]       idx;
   logic [ADDR_W-3:0]       rom_addr;
   logic                    neg_s1;
   logic                    neg_s2;
   logic [OUT_W-2:0]        mag;
   logic signed [OUT_W-1:0] dout_q;
   logic [3:0]              valid_sr;

   assign acc_sum = {1'b0, acc} + {1'b0, fcw_act};
   assign carry   = bus.en & ~bus.sync_clr & acc_sum[ACC_W];

   // Clear beats enable; a cleared cycle never reports a wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= carry;
         if (bus.sync_clr)  acc <= '0;
         else if (bus.en)   acc <= acc_sum[ACC_W-1:0];
      end
   end

   if (COHERENT) begin : g_coherent
      load_state_t      load_state;
      logic [ACC_W-1:0] pend;

      // A word accepted on a wrap edge is not the one released by that wrap
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            load_state  <= LOAD_IDLE;
            pend        <= '0;
            fcw_act     <= '0;
            fcw_ready_q <= 1'b1;
         end else begin
            case (load_state)
               LOAD_IDLE: begin
                  if (bus.fcw_valid) begin
                     pend        <= bus.fcw;
                     load_state  <= LOAD_PEND;
                     fcw_ready_q <= 1'b0;
                  end
               end
               LOAD_PEND: begin
                  if (carry || bus.sync_clr) begin
                     fcw_act     <= pend;
                     load_state  <= LOAD_IDLE;
                     fcw_ready_q <= 1'b1;
                  end
               end
               default: begin
                  load_state  <= LOAD_IDLE;
                  fcw_ready_q <= 1'b1;
               end
            endcase
         end
      end
   end else begin : g_direct
      assign fcw_ready_q = 1'b1;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)             fcw_act <= '0;
         else if (bus.fcw_valid) fcw_act <= bus.fcw;
      end
   end

   assign phase = acc[ACC_W-1 -: ADDR_W] + bus.phase_off;
   assign idx   = phase[ADDR_W-3:0];

   // Odd quadrants read the table backwards, the upper half is negated later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         neg_s1   <= 1'b0;
         neg_s2   <= 1'b0;
         dout_q   <= '0;
         valid_sr <= '0;
      end else begin
         rom_addr <= phase[ADDR_W-2+QUAD_MIRROR_BIT] ? ~idx : idx;
         neg_s1   <= phase[ADDR_W-2+QUAD_SIGN_BIT];
         neg_s2   <= neg_s1;
         dout_q   <= neg_s2 ? -{1'b0, mag} : {1'b0, mag};
         valid_sr <= {valid_sr[2:0], bus.en};
      end
   end

   ddfs_qw_rom #(
      .AW (ADDR_W - 2),
      .DW (OUT_W - 1)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (rom_addr),
      .mag   (mag)
   );

   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_sr[3];
   assign bus.wrap       = wrap_q;
   assign bus.fcw_ready  = fcw_ready_q;

endmodule

// File: tb/tb_ddfs_qw.sv
// Bench for ddfs_qw: a coherent and a direct-load instance driven in parallel
// and compared each cycle against a real-valued sine model.
module tb_ddfs_qw;

   localparam int     ACC_W   = 24;
   localparam int     ADDR_W  = 10;
   localparam int     OUT_W   = 8;
   localparam longint ACC_MOD = 64'd1 << ACC_W;
   localparam int     VW      = 2 * (OUT_W + 3);
   localparam real    PI      = 3.14159265358979323846;
   localparam logic [VW-1:0] RESET_VEC = {{OUT_W{1'b0}}, 3'b001, {OUT_W{1'b0}}, 3'b001};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              fcw_valid = 1'b0;
   logic              sync_clr = 1'b0;
   logic [ACC_W-1:0]  fcw = '0;
   logic [ADDR_W-1:0] phase_off = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   ddfs_qw_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus_c ();
   ddfs_qw_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus_d ();

   assign bus_c.en = en;
   assign bus_c.fcw = fcw;
   assign bus_c.fcw_valid = fcw_valid;
   assign bus_c.phase_off = phase_off;
   assign bus_c.sync_clr = sync_clr;
   assign bus_d.en = en;
   assign bus_d.fcw = fcw;
   assign bus_d.fcw_valid = fcw_valid;
   assign bus_d.phase_off = phase_off;
   assign bus_d.sync_clr = sync_clr;

   ddfs_qw #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .COHERENT(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c)
   );
   ddfs_qw #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .COHERENT(1'b0)) dut_d (
      .clk(clk), .rst_n(rst_n), .bus(bus_d)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference model: index 0 is the coherent unit, index 1 the direct-load unit
   longint   m_acc [2];
   longint   m_act [2];
   longint   m_pend [2];
   bit       m_pfull [2];
   bit       m_wrap [2];
   bit       m_ready [2];
   int       m_s1 [2];
   int       m_s2 [2];
   int       m_dout [2];
   bit [3:0] m_vld [2];

   function automatic int sine_ref(input int p);
      real amp;
      real x;
      amp = real'((1 << (OUT_W - 1)) - 1);
      x = amp * $sin(2.0 * PI * (real'(p) + 0.5) / real'(1 << ADDR_W));
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_acc[u] = 0;   m_act[u] = 0;  m_pend[u] = 0; m_pfull[u] = 1'b0;
         m_wrap[u] = 1'b0; m_ready[u] = 1'b1;
         m_s1[u] = 0; m_s2[u] = 0; m_dout[u] = 0; m_vld[u] = 4'b0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int u = 0; u < 2; u++) begin : model_unit
            longint sum;
            bit     cy;
            int     ph;
            sum = m_acc[u] + m_act[u];
            cy  = en && !sync_clr && (sum >= ACC_MOD);
            ph  = int'(((m_acc[u] >> (ACC_W - ADDR_W)) + longint'(phase_off)) % (64'd1 << ADDR_W));
            m_dout[u] = m_s2[u];
            m_s2[u]   = m_s1[u];
            m_s1[u]   = sine_ref(ph);
            m_vld[u]  = {m_vld[u][2:0], en};
            m_wrap[u] = cy;
            if (sync_clr)  m_acc[u] = 0;
            else if (en)   m_acc[u] = sum % ACC_MOD;
            if (u == 1) begin
               if (fcw_valid) m_act[u] = longint'(fcw);
            end else if (m_pfull[u]) begin
               if (cy || sync_clr) begin
                  m_act[u] = m_pend[u];
                  m_pfull[u] = 1'b0;
               end
            end else if (fcw_valid) begin
               m_pend[u] = longint'(fcw);
               m_pfull[u] = 1'b1;
            end
            m_ready[u] = (u == 1) ? 1'b1 : !m_pfull[u];
         end
      end
   end

   function automatic logic [VW-1:0] obs_vec();
      return {bus_c.dout, bus_c.dout_valid, bus_c.wrap, bus_c.fcw_ready,
              bus_d.dout, bus_d.dout_valid, bus_d.wrap, bus_d.fcw_ready};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {OUT_W'(m_dout[0]), m_vld[0][3], m_wrap[0], m_ready[0],
              OUT_W'(m_dout[1]), m_vld[1][3], m_wrap[1], m_ready[1]};
   endfunction

   function automatic bit carry_next();
      return (m_acc[0] + m_act[0]) >= ACC_MOD;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs_vec() !== RESET_VEC) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs_vec(), RESET_VEC);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      int last_wrap = -1;
      int max_s = -1000;
      int min_s = 1000;
      fcw = ACC_W'(1 << 14);
      fcw_valid = 1'b1;
      @(negedge clk);
      fcw_valid = 1'b0;
      sync_clr = 1'b1;
      en = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      for (int c = 0; c < 2100; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL basic_stream cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
         end
         if (bus_c.dout_valid) begin
            if (int'(bus_c.dout) > max_s) max_s = int'(bus_c.dout);
            if (int'(bus_c.dout) < min_s) min_s = int'(bus_c.dout);
         end
         if (bus_c.wrap) begin
            if (last_wrap >= 0) begin
               checks++;
               if (cyc - last_wrap != 1024) begin
                  errors++;
                  $display("[TB] FAIL basic_wrap_period: got %0d expected 1024", cyc - last_wrap);
               end
            end
            last_wrap = cyc;
         end
      end
      checks++;
      if (max_s != 127 || min_s != -127) begin
         errors++;
         $display("[TB] FAIL basic_peak_trough: got %0d/%0d expected 127/-127", max_s, min_s);
      end
   endtask

   task automatic test_phase_offset();
      logic [ADDR_W-1:0] offs [2];
      int                want [2];
      bit                seen;
      offs[0] = ADDR_W'(256); want[0] = 127;
      offs[1] = ADDR_W'(768); want[1] = -127;
      for (int t = 0; t < 2; t++) begin
         en = 1'b0;
         repeat (6) @(negedge clk);
         phase_off = offs[t];
         en = 1'b1;
         sync_clr = 1'b1;
         @(negedge clk);
         sync_clr = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 8 && !seen; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("[TB] FAIL phase_stream cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (bus_c.dout_valid) begin
               seen = 1'b1;
               checks++;
               if (int'(bus_c.dout) != want[t]) begin
                  errors++;
                  $display("[TB] FAIL phase_first_sample off=%0d: got %0d expected %0d", offs[t], bus_c.dout, want[t]);
               end
            end else begin
               @(negedge clk);
            end
         end
         if (!seen) begin
            errors++;
            $display("[TB] FAIL phase_valid_timeout off=%0d: got no dout_valid expected one", offs[t]);
         end
      end
      phase_off = '0;
   endtask

   task automatic test_coherent_load();
      int wrap1 = -1;
      int wrap2 = -1;
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      repeat ($urandom_range(400, 100)) @(negedge clk);
      fcw = ACC_W'(1 << 15);
      fcw_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_c.fcw_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL coh_ready_drop: got %b expected 0", bus_c.fcw_ready);
      end
      fcw = ACC_W'(3 << 14);
      repeat (5) @(negedge clk);
      fcw_valid = 1'b0;
      for (int c = 0; c < 1800 && wrap2 < 0; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL coh_stream cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
         end
         if (bus_c.wrap) begin
            if (wrap1 < 0) begin
               wrap1 = cyc;
               checks++;
               if (bus_c.fcw_ready !== 1'b1) begin
                  errors++;
                  $display("[TB] FAIL coh_ready_return: got %b expected 1", bus_c.fcw_ready);
               end
            end else begin
               wrap2 = cyc;
            end
         end
      end
      checks++;
      if (wrap2 < 0 || wrap2 - wrap1 != 512) begin
         errors++;
         $display("[TB] FAIL coh_new_step_period: got %0d expected 512", wrap2 - wrap1);
      end
   endtask

   task automatic test_wrap_offer();
      int  w0 = -1;
      int  w1 = -1;
      int  w2 = -1;
      bit  found = 1'b0;
      for (int c = 0; c < 700 && !found; c++) begin
         if (carry_next() && bus_c.fcw_ready) found = 1'b1;
         else @(negedge clk);
      end
      if (!found) begin
         errors++;
         $display("[TB] FAIL wrapoffer_timeout: got no wrap expected one");
      end
      fcw = ACC_W'(1 << 14);
      fcw_valid = 1'b1;
      @(negedge clk);
      fcw_valid = 1'b0;
      checks++;
      if ({bus_c.wrap, bus_c.fcw_ready} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL wrapoffer_accept: got wrap/ready %b%b expected 10", bus_c.wrap, bus_c.fcw_ready);
      end
      w0 = cyc;
      for (int c = 0; c < 1700 && w2 < 0; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL wrapoffer_stream cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
         end
         if (bus_c.wrap) begin
            if (w1 < 0) w1 = cyc;
            else        w2 = cyc;
         end
      end
      checks++;
      if (w1 - w0 != 512 || w2 - w1 != 1024) begin
         errors++;
         $display("[TB] FAIL wrapoffer_periods: got %0d/%0d expected 512/1024", w1 - w0, w2 - w1);
      end
   endtask

   task automatic test_direct_load();
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(80, 20)) @(negedge clk);
         fcw = (r == 0) ? ACC_W'(1 << 15) : ACC_W'($urandom_range(1 << 20, 1 << 12));
         fcw_valid = 1'b1;
         checks++;
         if (bus_d.fcw_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL direct_ready: got %b expected 1", bus_d.fcw_ready);
         end
         @(negedge clk);
         fcw_valid = 1'b0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("[TB] FAIL direct_stream cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   task automatic test_enable_gap();
      int  low_cnt = 0;
      int  gap_wraps = 0;
      bit  prev_en;
      en = 1'b1;
      repeat (8) @(negedge clk);
      for (int c = 0; c < 40; c++) begin
         prev_en = en;
         en = !(c >= 2 && c < 12);
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL engap_stream cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
         end
         if (!bus_c.dout_valid) low_cnt++;
         if (!en && bus_c.wrap) gap_wraps++;
      end
      checks++;
      if (low_cnt != 10 || gap_wraps != 0) begin
         errors++;
         $display("[TB] FAIL engap_counts: got low=%0d wraps=%0d expected low=10 wraps=0", low_cnt, gap_wraps);
      end
      en = 1'b1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         en        = ($urandom_range(99, 0) < 90);
         phase_off = ADDR_W'($urandom);
         fcw_valid = ($urandom_range(99, 0) < 5);
         fcw       = ACC_W'($urandom_range(1 << 20, 1 << 12));
         sync_clr  = ($urandom_range(99, 0) < 1);
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL random_stream cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
         end
      end
      fcw_valid = 1'b0;
      sync_clr  = 1'b0;
      en        = 1'b1;
   endtask

   task automatic test_reset_midstream();
      fcw = ACC_W'(1 << 13);
      fcw_valid = 1'b1;
      @(negedge clk);
      fcw_valid = 1'b0;
      checks++;
      if (bus_c.fcw_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_pending: got %b expected 0", bus_c.fcw_ready);
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== RESET_VEC) begin
         errors++;
         $display("[TB] FAIL midreset_async: got %h expected %h", obs_vec(), RESET_VEC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec() || bus_c.dout_valid !== (k == 4)) begin
            errors++;
            $display("[TB] FAIL midreset_release edge %0d: got %h valid %b expected %h valid %b",
                     k, obs_vec(), bus_c.dout_valid, exp_vec(), (k == 4));
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_phase_offset();
      test_coherent_load();
      test_wrap_offer();
      test_direct_load();
      test_enable_gap();
      test_random();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
